sd_decim_cic3: RTL and testbench

//  Receive-side companion to the 2nd-order 1b sigma-delta DAC: 3rd-order CIC (sinc3)

---
 rtl/sd_decim_cic3_if.sv | 21 ++
 rtl/sd_decim_cic3.sv | 113 +++++++++++
 tb/tb_sd_decim_cic3.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_decim_cic3_if.sv
// Bitstream input strobe plus decimated-word output handshake for sd_decim_cic3.
interface sd_decim_cic3_if #(
   parameter int DOUT_W = 16
);
   logic              sd_en;
   logic              sd_in;
   logic [DOUT_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              overrun;

   modport master (
      input  sd_en, sd_in, dout_ready,
      output dout, dout_valid, overrun
   );

   modport slave (
      output sd_en, sd_in, dout_ready,
      input  dout, dout_valid, overrun
   );
endinterface

// File: rtl/sd_decim_cic3.sv
// Sinc3 CIC decimator: 1-bit sigma-delta stream -> 16-bit unsigned words, R = 2**DECIM_LOG2.
// Optional macro SD_DECIM_WARMUP_EN suppresses the first 3 (transient) words after reset.
module sd_decim_cic3 #(
   parameter int DECIM_LOG2 = 6,
   parameter int DOUT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_sd,
   sd_decim_cic3_if.master  bus
);
   localparam int ACC_W = 3*DECIM_LOG2 + 1;
   localparam int SHIFT = 3*DECIM_LOG2 - 16;
   localparam int W_W   = ACC_W - SHIFT;

   logic [DECIM_LOG2-1:0] cnt_reg;
   logic [ACC_W-1:0]      integ [3];
   logic [ACC_W-1:0]      comb  [3];
   logic [W_W-1:0]        w;
   logic [DOUT_W-1:0]     w_sat;
   logic                  tick;
   logic                  present;
   logic                  load;

   assign tick = bus.sd_en && (cnt_reg == '1);

   always_ff @(posedge clk or posedge rst_sd) begin
      if (rst_sd) begin
         cnt_reg <= '0;
      end else if (bus.sd_en) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_int
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] add_in;
         if (gi == 0) begin : g_first
            assign add_in = {{(ACC_W-1){1'b0}}, bus.sd_in};
         end else begin : g_chain
            assign add_in = integ[gi-1];
         end
         always_ff @(posedge clk or posedge rst_sd) begin
            if (rst_sd) begin
               acc_reg <= '0;
            end else if (bus.sd_en) begin
               acc_reg <= acc_reg + add_in;
            end
         end
         assign integ[gi] = acc_reg;
      end

      // Comb stages run at the decimated rate; each delay captures its own stage input.
      for (gi = 0; gi < 3; gi++) begin : g_comb
         logic [ACC_W-1:0] dly_reg;
         logic [ACC_W-1:0] comb_in;
         if (gi == 0) begin : g_first
            assign comb_in = integ[2];
         end else begin : g_chain
            assign comb_in = comb[gi-1];
         end
         always_ff @(posedge clk or posedge rst_sd) begin
            if (rst_sd) begin
               dly_reg <= '0;
            end else if (tick) begin
               dly_reg <= comb_in;
            end
         end
         assign comb[gi] = comb_in - dly_reg;
      end
   endgenerate

   // Full-scale ones input gives exactly 2**16 after the shift, so clamp to 65535.
   assign w     = comb[2][ACC_W-1:SHIFT];
   assign w_sat = w[W_W-1] ? '1 : w[DOUT_W-1:0];

`ifdef SD_DECIM_WARMUP_EN
   logic [1:0] warm_reg;

   always_ff @(posedge clk or posedge rst_sd) begin
      if (rst_sd) begin
         warm_reg <= 2'd0;
      end else if (tick && (warm_reg != 2'd3)) begin
         warm_reg <= warm_reg + 2'd1;
      end
   end

   assign present = (warm_reg == 2'd3);
`else
   assign present = 1'b1;
`endif

   assign load = tick && present;

   always_ff @(posedge clk or posedge rst_sd) begin
      if (rst_sd) begin
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         if (load) begin
            bus.dout       <= w_sat;
            bus.dout_valid <= 1'b1;
            if (bus.dout_valid && !bus.dout_ready) begin
               bus.overrun <= 1'b1;
            end
         end else if (bus.dout_valid && bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sd_decim_cic3.sv
// Bench for sd_decim_cic3: closed-form sinc3 reference (binomial-weighted sums over the
// captured bitstream) plus literal pins; directed scenarios followed by random stimulus.
module tb_sd_decim_cic3;
   localparam int DL    = 6;
   localparam int R     = 1 << DL;
   localparam int SHIFT = 3*DL - 16;
`ifdef SD_DECIM_WARMUP_EN
   localparam int WARM  = 3;
`else
   localparam int WARM  = 0;
`endif

   logic clk = 1'b0;
   logic rst_sd;
   sd_decim_cic3_if sif ();

   sd_decim_cic3 #(.DECIM_LOG2(DL)) dut (
      .clk    (clk),
      .rst_sd (rst_sd),
      .bus    (sif.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference state
   int     xs[$];
   longint sv[$];
   int     kt;
   int     m_dout;
   bit     m_valid;
   bit     m_ovr;

   // stimulus control
   int cyc_ctr;
   int in_mode;   // 0 hold, 1 alternate per sample, 2 random
   int en_div;
   bit en_rand;
   bit rdy_rand;
   bit alt;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // i3 after n samples = sum_j x[j] * C(n-1-j, 2)
   function automatic longint s_of(input int n);
      longint acc = 0;
      for (int j = 0; j < n; j++) begin
         if (xs[j] != 0) acc += (longint'(n-1-j) * longint'(n-2-j)) / 2;
      end
      return acc;
   endfunction

   function automatic longint s_at(input int k);
      return (k >= 1) ? sv[k-1] : 64'sd0;
   endfunction

   function automatic int word_of(input int k);
      longint c;
      longint w;
      c = s_at(k) - 3*s_at(k-1) + 3*s_at(k-2) - s_at(k-3);
      w = c >>> SHIFT;
      return (w > 65535) ? 65535 : int'(w);
   endfunction

   function automatic void model_reset();
      xs.delete();
      sv.delete();
      kt      = 0;
      m_dout  = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      alt     = 1'b1;
   endfunction

   task automatic model_edge(input bit e, input bit b, input bit r);
      bit ld = 1'b0;
      int wv = 0;
      if (e) begin
         xs.push_back(int'(b));
         if ((xs.size() % R) == 0) begin
            kt++;
            sv.push_back(s_of(xs.size() - 1));
            wv = word_of(kt);
            ld = (kt > WARM);
         end
      end
      if (ld) begin
         if (m_valid && !r) m_ovr = 1'b1;
         m_dout  = wv;
         m_valid = 1'b1;
         $display("word %0d: dout=%0d ready=%0b", kt, wv, r);
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic cycle();
      bit e, b, r;
      @(posedge clk);
      e = sif.sd_en;
      b = sif.sd_in;
      r = sif.dout_ready;
      model_edge(e, b, r);
      #1;
      chk("dout", longint'(sif.dout), longint'(m_dout));
      chk("dout_valid", longint'(sif.dout_valid), longint'(m_valid));
      chk("overrun", longint'(sif.overrun), longint'(m_ovr));
   endtask

   task automatic drive_and_cycle();
      bit e;
      if (en_rand) e = ($urandom_range(3, 0) != 0);
      else         e = ((cyc_ctr % en_div) == 0);
      cyc_ctr++;
      sif.sd_en = e;
      if (e) begin
         if (in_mode == 1) begin
            sif.sd_in = alt;
            alt = !alt;
         end else if (in_mode == 2) begin
            sif.sd_in = $urandom_range(1, 0) != 0;
         end
      end
      if (rdy_rand) sif.dout_ready = $urandom_range(1, 0) != 0;
      cycle();
   endtask

   task automatic run_to_tick(input int target);
      int budget = 4 * R * (target + 2);
      while (kt < target && budget > 0) begin
         drive_and_cycle();
         budget--;
      end
      if (kt < target) chk("tick_timeout", kt, target);
   endtask

   task automatic apply_reset();
      #2;
      rst_sd = 1'b1;
      model_reset();
      #1;
      chk("rst_dout", longint'(sif.dout), 0);
      chk("rst_valid", longint'(sif.dout_valid), 0);
      chk("rst_overrun", longint'(sif.overrun), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_sd = 1'b0;
      cyc_ctr = 0;
   endtask

   task automatic setup(input int mode, input bit inval, input int div);
      in_mode  = mode;
      en_div   = div;
      en_rand  = 1'b0;
      rdy_rand = 1'b0;
      sif.sd_in      = inval;
      sif.sd_en      = 1'b0;
      sif.dout_ready = 1'b1;
   endtask

   initial begin
      int t4, t5, c;
      rst_sd = 1'b1;
      setup(0, 1'b0, 1);
      model_reset();

      // all ones: transient words then saturation
      apply_reset();
      setup(0, 1'b1, 1);
      run_to_tick(1);
`ifdef SD_DECIM_WARMUP_EN
      chk("t1_w1_hidden", longint'(sif.dout_valid), 0);
`else
      chk("t1_w1_valid", longint'(sif.dout_valid), 1);
      chk("t1_w1_dout", longint'(sif.dout), 9927);
      run_to_tick(2);
      chk("t1_w2_dout", longint'(sif.dout), 53560);
`endif
      run_to_tick(4);
      chk("t1_w4_valid", longint'(sif.dout_valid), 1);
      chk("t1_w4_dout", longint'(sif.dout), 65535);
      run_to_tick(6);
      chk("t1_w6_dout", longint'(sif.dout), 65535);
      chk("t1_overrun", longint'(sif.overrun), 0);

      // all zeros: single-cycle valid pulses
      apply_reset();
      setup(0, 1'b0, 1);
      run_to_tick(4);
      chk("t2_dout", longint'(sif.dout), 0);
      drive_and_cycle();
      chk("t2_pulse_end", longint'(sif.dout_valid), 0);

      // alternating bits, full rate then half-rate strobe
      apply_reset();
      setup(1, 1'b0, 1);
      run_to_tick(5);
      chk("t3_dout", longint'(sif.dout), 32768);
      apply_reset();
      setup(1, 1'b0, 2);
      run_to_tick(4);
      t4 = cyc_ctr;
      run_to_tick(5);
      t5 = cyc_ctr;
      chk("t3_dout_half", longint'(sif.dout), 32768);
      chk("t3_period", t5 - t4, 2*R);

      // stalled consumer: overwrite sets sticky overrun
      apply_reset();
      setup(0, 1'b1, 1);
      run_to_tick(4);
      drive_and_cycle();
      sif.dout_ready = 1'b0;
      run_to_tick(5);
      chk("t4_ovr_first", longint'(sif.overrun), 0);
      run_to_tick(6);
      chk("t4_ovr_second", longint'(sif.overrun), 1);
      run_to_tick(7);
      chk("t4_valid_held", longint'(sif.dout_valid), 1);
      sif.dout_ready = 1'b1;
      cycle();
      chk("t4_valid_drop", longint'(sif.dout_valid), 0);
      chk("t4_ovr_sticky", longint'(sif.overrun), 1);

      // reset mid-window then restart latency
      apply_reset();
      setup(2, 1'b0, 1);
      c = 0;
      while (!(xs.size() > R && (xs.size() % R) == 30) && c < 400) begin
         drive_and_cycle();
         c++;
      end
      chk("t5_reach_cnt30", (xs.size() % R), 30);
      apply_reset();
      c = 0;
      while (!sif.dout_valid && c < 8*R) begin
         drive_and_cycle();
         c++;
      end
      chk("t5_latency", c, (WARM + 1) * R);

      // random bitstream, strobe and consumer
      apply_reset();
      setup(2, 1'b0, 1);
      en_rand  = 1'b1;
      rdy_rand = 1'b1;
      for (int i = 0; i < 3000; i++) drive_and_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
